homography_arbiter: RTL and testbench
=====================================

// Module: homography_arbiter
// PURPOSE
//   Shares one homography/CCD lookup engine between two pixel-stream requesters (A, B).
//   - Arbitrates queries round-robin and issues one start pulse per query to the engine.
//   - Tags every in-flight query and routes each in-order engine response back to its issuer.
//   - Sits between the sync controllers and the homography engine on clk_25.
// PARAMETERS
//   DEPTH    4   max queries in flight; tag FIFO depth, power of 2, >=2
//   AW       2   log2(DEPTH); tag FIFO pointer width
// PORTS
//   clk_25      in   1   pixel clock; all logic on posedge
//   rst_n       in   1   reset, asynchronous, active-low
//   a_valid     in   1   requester A has a query; holds a_x/a_y stable until a_ack
//   a_x, a_y    in   10  requester A query coordinates
//   a_ack       out  1   1-cycle pulse: A query accepted
//   a_rvalid    out  1   1-cycle pulse: a_rdata holds a response for A
//   a_rdata     out  36  {x[35:26], y[25:16], r[15:11], g[10:5], b[4:0]}
//   b_*         --   --  same set as a_* for requester B
//   eng_start   out  1   1-cycle pulse: eng_x/eng_y valid, engine starts a lookup
//   eng_x       out  10  query x to engine
//   eng_y       out  10  query y to engine
//   eng_ready   in   1   1-cycle pulse: eng_rdata valid; responses return in issue order
//   eng_rdata   in   36  engine response, packed like a_rdata
//   outstanding out  AW+1  queries issued and not yet answered (0..DEPTH)
//   err         out  1   sticky: eng_ready arrived with outstanding==0
// BEHAVIOUR
//   Reset (async): all outputs 0 (including err and outstanding).
//     - Tag FIFO is emptied and priority goes to A.
//     - Queries in flight at reset are discarded; any later eng_ready counts as error.
//   Eligibility: requester X is eligible when x_valid=1 and x_ack=0 this cycle.
//     - The ack-cycle request is the one just accepted, so it is never granted twice.
//   Grant: made when outstanding<DEPTH and at least one requester is eligible.
//     - Pick the eligible requester; if both are eligible, the priority holder wins.
//     - A grant takes effect at the next edge:
//       - eng_start=1, eng_x/eng_y=granted coordinates, x_ack=1 for the winner.
//       - Push tag (0=A, 1=B) and move priority to the other requester.
//     - No grant: eng_start=0, both acks 0, eng_x/eng_y keep their last value, priority unchanged.
//   Full: with outstanding==DEPTH, no grant, even if eng_ready is high that cycle.
//     - Granting resumes the cycle after the count drops.
//   Response, when eng_ready=1 and outstanding>0:
//     - Pop the tag at the head of the FIFO.
//     - At the next edge: owner's x_rvalid=1 and x_rdata=eng_rdata; the other rvalid=0.
//     - Latency from eng_ready to rvalid is 1 cycle.
//     - x_rdata holds its value between responses.
//   Response, when eng_ready=1 and outstanding==0:
//     - The response is dropped, no rvalid is raised, and err is set to 1 until reset.
//   Grant and pop in the same cycle: push and pop both happen; outstanding stays the same.
//   outstanding: +1 on grant, -1 on valid pop; it is a register that never wraps.
//   FIFO pointers: AW bits, wrap modulo DEPTH.
//   Throughput:
//     - With both requesters always valid: one grant per cycle, alternating A,B,A,B.
//     - A single requester: one grant every 2 cycles.
// TESTING
//   T1 single: a_valid with (5,7), engine answers 3 cycles after start.
//      -> a_ack and eng_start in the same cycle with eng_x=5, eng_y=7.
//      -> a_rvalid 1 cycle after eng_ready with a_rdata=eng_rdata; b_rvalid stays 0.
//   T2 contention: a_valid and b_valid both held high from reset.
//      -> grants go A,B,A,B on consecutive cycles.
//      -> responses are routed A,B,A,B in order; no requester is starved.
//   T3 full: engine silent, A and B both valid.
//      -> exactly 4 grants, outstanding=4, then no eng_start.
//      -> one eng_ready: outstanding=3 and a grant the next cycle.
//   T4 simultaneous: eng_ready in the same cycle as a grant at outstanding=2.
//      -> outstanding stays 2, and the response goes to the oldest tag.
//   T5 spurious: eng_ready with outstanding=0.
//      -> err=1 and stays 1; no rvalid; later traffic works normally.
//   T6 reset mid-op: assert rst_n=0 with 3 queries in flight.
//      -> all outputs 0 and outstanding=0.
//      -> after release, an eng_ready sets err; the next A query is granted first.

Source files
------------

// File: rtl/homography_arbiter.sv
// homography_arbiter: shares one homography/CCD lookup engine between two
// pixel-stream requesters (A and B). Queries are granted round-robin, each
// grant pushes a one-bit owner tag, and the in-order engine responses are
// routed back to their issuer by popping that tag.
module homography_arbiter #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic          clk_25,
  input  logic          rst_n,
  input  logic          a_valid,
  input  logic [9:0]    a_x,
  input  logic [9:0]    a_y,
  output logic          a_ack,
  output logic          a_rvalid,
  output logic [35:0]   a_rdata,
  input  logic          b_valid,
  input  logic [9:0]    b_x,
  input  logic [9:0]    b_y,
  output logic          b_ack,
  output logic          b_rvalid,
  output logic [35:0]   b_rdata,
  output logic          eng_start,
  output logic [9:0]    eng_x,
  output logic [9:0]    eng_y,
  input  logic          eng_ready,
  input  logic [35:0]   eng_rdata,
  output logic [AW:0]   outstanding,
  output logic          err
);

  typedef enum logic {
    PRIO_A = 1'b0,
    PRIO_B = 1'b1
  } prio_e;

  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  prio_e         prio_q, prio_d;
  logic          a_ack_q, a_ack_d;
  logic          b_ack_q, b_ack_d;
  logic          eng_start_q, eng_start_d;
  logic [9:0]    eng_x_q, eng_x_d;
  logic [9:0]    eng_y_q, eng_y_d;
  logic          a_rvalid_q, a_rvalid_d;
  logic          b_rvalid_q, b_rvalid_d;
  logic [35:0]   a_rdata_q, a_rdata_d;
  logic [35:0]   b_rdata_q, b_rdata_d;
  logic [AW:0]   outstanding_q, outstanding_d;
  logic          err_q, err_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic          tag_mem_q [DEPTH];
  logic          tag_mem_d [DEPTH];

  logic          a_elig;
  logic          b_elig;
  logic          fifo_full;
  logic          fifo_empty;
  logic          grant;
  logic          pick_b;
  logic          pop;
  logic          head_tag;

  // Eligibility and grant decision; a requester acked this cycle is skipped so its accepted query is not granted twice
  always_comb begin
    a_elig     = a_valid & ~a_ack_q;
    b_elig     = b_valid & ~b_ack_q;
    fifo_full  = (outstanding_q == FULL_CNT);
    fifo_empty = (outstanding_q == '0);
    grant      = ~fifo_full & (a_elig | b_elig);
    pick_b     = b_elig & (~a_elig | (prio_q == PRIO_B));
    pop        = eng_ready & ~fifo_empty;
    head_tag   = tag_mem_q[rd_ptr_q];
  end

  // Grant side: engine start, winner ack, coordinate capture and priority hand-over
  always_comb begin
    a_ack_d     = 1'b0;
    b_ack_d     = 1'b0;
    eng_start_d = 1'b0;
    eng_x_d     = eng_x_q;
    eng_y_d     = eng_y_q;
    prio_d      = prio_q;
    if (grant) begin
      eng_start_d = 1'b1;
      if (pick_b) begin
        b_ack_d = 1'b1;
        eng_x_d = b_x;
        eng_y_d = b_y;
        prio_d  = PRIO_A;
      end else begin
        a_ack_d = 1'b1;
        eng_x_d = a_x;
        eng_y_d = a_y;
        prio_d  = PRIO_B;
      end
    end
  end

  // Tag FIFO push/pop and in-flight counter; simultaneous push and pop leave the count unchanged
  always_comb begin
    tag_mem_d     = tag_mem_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    outstanding_d = outstanding_q;
    if (grant) begin
      tag_mem_d[wr_ptr_q] = pick_b;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    if (grant && !pop) begin
      outstanding_d = outstanding_q + CNT_ONE;
    end else if (!grant && pop) begin
      outstanding_d = outstanding_q - CNT_ONE;
    end
  end

  // Response routing by head tag; a response with nothing in flight is dropped and latches the error flag
  always_comb begin
    a_rvalid_d = 1'b0;
    b_rvalid_d = 1'b0;
    a_rdata_d  = a_rdata_q;
    b_rdata_d  = b_rdata_q;
    err_d      = err_q;
    if (pop) begin
      if (head_tag) begin
        b_rvalid_d = 1'b1;
        b_rdata_d  = eng_rdata;
      end else begin
        a_rvalid_d = 1'b1;
        a_rdata_d  = eng_rdata;
      end
    end
    if (eng_ready && fifo_empty) begin
      err_d = 1'b1;
    end
  end

  // State registers; reset discards in-flight queries and returns priority to A
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      prio_q        <= PRIO_A;
      a_ack_q       <= 1'b0;
      b_ack_q       <= 1'b0;
      eng_start_q   <= 1'b0;
      eng_x_q       <= '0;
      eng_y_q       <= '0;
      a_rvalid_q    <= 1'b0;
      b_rvalid_q    <= 1'b0;
      a_rdata_q     <= '0;
      b_rdata_q     <= '0;
      outstanding_q <= '0;
      err_q         <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        tag_mem_q[i] <= 1'b0;
      end
    end else begin
      prio_q        <= prio_d;
      a_ack_q       <= a_ack_d;
      b_ack_q       <= b_ack_d;
      eng_start_q   <= eng_start_d;
      eng_x_q       <= eng_x_d;
      eng_y_q       <= eng_y_d;
      a_rvalid_q    <= a_rvalid_d;
      b_rvalid_q    <= b_rvalid_d;
      a_rdata_q     <= a_rdata_d;
      b_rdata_q     <= b_rdata_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      tag_mem_q     <= tag_mem_d;
    end
  end

  assign a_ack       = a_ack_q;
  assign b_ack       = b_ack_q;
  assign eng_start   = eng_start_q;
  assign eng_x       = eng_x_q;
  assign eng_y       = eng_y_q;
  assign a_rvalid    = a_rvalid_q;
  assign b_rvalid    = b_rvalid_q;
  assign a_rdata     = a_rdata_q;
  assign b_rdata     = b_rdata_q;
  assign outstanding = outstanding_q;
  assign err         = err_q;

endmodule

// File: tb/tb_homography_arbiter.sv
// tb_homography_arbiter: requester drivers, a stub lookup engine and a response
// scoreboard around homography_arbiter, plus directed scenarios for single
// query, contention, full, simultaneous push/pop, spurious response and reset.
module tb_homography_arbiter;

  typedef struct {
    logic [9:0] x;
    logic [9:0] y;
    int         cyc;
  } pend_t;

  typedef struct {
    bit          owner;
    logic [35:0] data;
  } exp_t;

  logic        clk_25;
  logic        rst_n;
  logic        a_valid;
  logic [9:0]  a_x;
  logic [9:0]  a_y;
  logic        a_ack;
  logic        a_rvalid;
  logic [35:0] a_rdata;
  logic        b_valid;
  logic [9:0]  b_x;
  logic [9:0]  b_y;
  logic        b_ack;
  logic        b_rvalid;
  logic [35:0] b_rdata;
  logic        eng_start;
  logic [9:0]  eng_x;
  logic [9:0]  eng_y;
  logic        eng_ready;
  logic [35:0] eng_rdata;
  logic [2:0]  outstanding;
  logic        err;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          rsp_a = 0;
  int          rsp_b = 0;
  int          n;
  bit          first_ok;

  logic [19:0] a_q[$];
  logic [19:0] b_q[$];
  pend_t       eng_pend[$];
  exp_t        sb[$];
  bit          gnt_log[$];
  int          gnt_cyc[$];
  bit          resp_due = 1'b0;
  bit          eng_auto = 1'b0;
  bit          release_one = 1'b0;
  bit          spurious_req = 1'b0;

  homography_arbiter #(.DEPTH(4), .AW(2)) dut (
    .clk_25      (clk_25),
    .rst_n       (rst_n),
    .a_valid     (a_valid),
    .a_x         (a_x),
    .a_y         (a_y),
    .a_ack       (a_ack),
    .a_rvalid    (a_rvalid),
    .a_rdata     (a_rdata),
    .b_valid     (b_valid),
    .b_x         (b_x),
    .b_y         (b_y),
    .b_ack       (b_ack),
    .b_rvalid    (b_rvalid),
    .b_rdata     (b_rdata),
    .eng_start   (eng_start),
    .eng_x       (eng_x),
    .eng_y       (eng_y),
    .eng_ready   (eng_ready),
    .eng_rdata   (eng_rdata),
    .outstanding (outstanding),
    .err         (err)
  );

  // 25 MHz pixel clock
  initial begin
    clk_25 = 1'b0;
    forever #20 clk_25 = ~clk_25;
  end

  // Hard stop in case something wedges
  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: observed no finish, expected finish before 2ms");
    $fatal(1, "[TB] watchdog expired");
  end

  // Stub engine response: echoes the query coordinates and derives a colour from them
  function automatic logic [35:0] engData(input logic [9:0] x, input logic [9:0] y);
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
    r = x[4:0] ^ y[4:0];
    g = x[5:0] + y[5:0];
    b = x[9:5] ^ y[9:5];
    return {x, y, r, g, b};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Queue one query for a requester; A queries keep x < 512, B queries use x >= 512
  task automatic applyStimulus(input bit who, input logic [9:0] x, input logic [9:0] y);
    if (who) b_q.push_back({x, y});
    else     a_q.push_back({x, y});
  endtask

  task automatic waitCycles(input int cnt);
    repeat (cnt) @(negedge clk_25);
    #2;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
  endtask

  task automatic drainAll(input string tag);
    int k;
    eng_auto = 1'b1;
    k = 0;
    while ((a_q.size() != 0 || b_q.size() != 0 || eng_pend.size() != 0 ||
            sb.size() != 0 || resp_due) && k < 80) begin
      waitCycles(1);
      k++;
    end
    checkOutput({tag, "_done"}, 64'(k < 80), 64'd1);
    checkOutput({tag, "_outstanding"}, 64'(outstanding), 64'd0);
  endtask

  // Per-cycle bench agent: scoreboard compare, engine capture, requester drivers, engine responses
  always @(negedge clk_25) begin
    pend_t p;
    exp_t  e;
    cyc++;
    if (!rst_n) begin
      a_q.delete();
      b_q.delete();
      eng_pend.delete();
      sb.delete();
      resp_due  = 1'b0;
      a_valid   = 1'b0;
      b_valid   = 1'b0;
      eng_ready = 1'b0;
    end else begin
      if (resp_due) begin
        e = sb.pop_front();
        if (!e.owner) begin
          checkOutput("rsp_a_rvalid", 64'(a_rvalid), 64'd1);
          checkOutput("rsp_a_rdata", 64'(a_rdata), 64'(e.data));
          checkOutput("rsp_b_quiet", 64'(b_rvalid), 64'd0);
          if (a_rvalid) rsp_a++;
        end else begin
          checkOutput("rsp_b_rvalid", 64'(b_rvalid), 64'd1);
          checkOutput("rsp_b_rdata", 64'(b_rdata), 64'(e.data));
          checkOutput("rsp_a_quiet", 64'(a_rvalid), 64'd0);
          if (b_rvalid) rsp_b++;
        end
        resp_due = 1'b0;
      end else if (a_rvalid || b_rvalid) begin
        checkOutput("stray_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
      end

      if (eng_start || a_ack || b_ack) begin
        checkOutput("start_one_ack", 64'({eng_start, a_ack ^ b_ack}), 64'd3);
      end
      if (eng_start) begin
        p.x   = eng_x;
        p.y   = eng_y;
        p.cyc = cyc;
        eng_pend.push_back(p);
        gnt_log.push_back(b_ack);
        gnt_cyc.push_back(cyc);
      end
      if (a_ack) begin
        checkOutput("a_ack_has_query", 64'(a_q.size() != 0), 64'd1);
        if (a_q.size() != 0) begin
          checkOutput("a_eng_xy", 64'({eng_x, eng_y}), 64'(a_q[0]));
          void'(a_q.pop_front());
        end
      end
      if (b_ack) begin
        checkOutput("b_ack_has_query", 64'(b_q.size() != 0), 64'd1);
        if (b_q.size() != 0) begin
          checkOutput("b_eng_xy", 64'({eng_x, eng_y}), 64'(b_q[0]));
          void'(b_q.pop_front());
        end
      end

      a_valid = (a_q.size() != 0);
      if (a_valid) {a_x, a_y} = a_q[0];
      b_valid = (b_q.size() != 0);
      if (b_valid) {b_x, b_y} = b_q[0];

      eng_ready = 1'b0;
      if (spurious_req) begin
        eng_ready    = 1'b1;
        eng_rdata    = 36'hA_5A5A_5A5A;
        spurious_req = 1'b0;
      end else if (eng_pend.size() != 0 &&
                   (release_one || (eng_auto && (cyc - eng_pend[0].cyc) >= 2))) begin
        p         = eng_pend.pop_front();
        eng_ready = 1'b1;
        eng_rdata = engData(p.x, p.y);
        e.owner   = p.x[9];
        e.data    = eng_rdata;
        sb.push_back(e);
        resp_due    = 1'b1;
        release_one = 1'b0;
      end
    end
  end

  // Directed scenarios
  initial begin
    rst_n     = 1'b0;
    a_valid   = 1'b0;
    a_x       = '0;
    a_y       = '0;
    b_valid   = 1'b0;
    b_x       = '0;
    b_y       = '0;
    eng_ready = 1'b0;
    eng_rdata = '0;
    waitCycles(3);

    $display("[TB] reset state");
    checkOutput("rst_ctrl", 64'({a_ack, b_ack, a_rvalid, b_rvalid, eng_start, err, outstanding}), 64'd0);
    checkOutput("rst_a_rdata", 64'(a_rdata), 64'd0);
    checkOutput("rst_b_rdata", 64'(b_rdata), 64'd0);
    checkOutput("rst_eng_xy", 64'({eng_x, eng_y}), 64'd0);
    rst_n = 1'b1;
    waitCycles(1);

    $display("[TB] T1 single query");
    eng_auto = 1'b1;
    applyStimulus(1'b0, 10'd5, 10'd7);
    n = 0;
    while (!eng_start && n < 10) begin
      waitCycles(1);
      n++;
    end
    checkOutput("t1_start", 64'(eng_start), 64'd1);
    checkOutput("t1_acks", 64'({a_ack, b_ack}), 64'b10);
    checkOutput("t1_eng_xy", 64'({eng_x, eng_y}), 64'({10'd5, 10'd7}));
    checkOutput("t1_outstanding", 64'(outstanding), 64'd1);
    n = 0;
    while (!a_rvalid && n < 10) begin
      waitCycles(1);
      n++;
    end
    checkOutput("t1_rvalid", 64'({a_rvalid, b_rvalid}), 64'b10);
    checkOutput("t1_rdata", 64'(a_rdata), 64'(engData(10'd5, 10'd7)));
    waitCycles(1);
    checkOutput("t1_rvalid_pulse", 64'(a_rvalid), 64'd0);
    checkOutput("t1_rdata_hold", 64'(a_rdata), 64'(engData(10'd5, 10'd7)));
    checkOutput("t1_outstanding_end", 64'(outstanding), 64'd0);

    $display("[TB] T2 contention");
    doReset();
    eng_auto = 1'b1;
    gnt_log.delete();
    gnt_cyc.delete();
    rsp_a = 0;
    rsp_b = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 10'(20 + i), 10'(40 + i));
      applyStimulus(1'b1, 10'(600 + i), 10'(100 + i));
    end
    n = 0;
    while (gnt_log.size() < 8 && n < 40) begin
      waitCycles(1);
      n++;
    end
    checkOutput("t2_grants", 64'(gnt_log.size()), 64'd8);
    for (int i = 0; i < gnt_log.size(); i++) begin
      checkOutput("t2_order", 64'(gnt_log[i]), 64'(i % 2));
      if (i > 0) checkOutput("t2_back_to_back", 64'(gnt_cyc[i] - gnt_cyc[i-1]), 64'd1);
    end
    drainAll("t2_drain");
    checkOutput("t2_rsp_a", 64'(rsp_a), 64'd4);
    checkOutput("t2_rsp_b", 64'(rsp_b), 64'd4);

    $display("[TB] T3 full");
    doReset();
    eng_auto = 1'b0;
    gnt_log.delete();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 10'(30 + i), 10'(50 + i));
      applyStimulus(1'b1, 10'(700 + i), 10'(60 + i));
    end
    waitCycles(8);
    checkOutput("t3_grants", 64'(gnt_log.size()), 64'd4);
    checkOutput("t3_full", 64'(outstanding), 64'd4);
    checkOutput("t3_no_start", 64'(eng_start), 64'd0);
    release_one = 1'b1;
    waitCycles(2);
    checkOutput("t3_after_pop", 64'({outstanding, eng_start}), 64'({3'd3, 1'b0}));
    waitCycles(1);
    checkOutput("t3_resume", 64'({eng_start, a_ack, outstanding}), 64'({1'b1, 1'b1, 3'd4}));
    drainAll("t3_drain");

    $display("[TB] T4 simultaneous grant and response");
    doReset();
    eng_auto = 1'b0;
    applyStimulus(1'b0, 10'd111, 10'd222);
    applyStimulus(1'b1, 10'd888, 10'd333);
    waitCycles(5);
    checkOutput("t4_two_inflight", 64'(outstanding), 64'd2);
    applyStimulus(1'b0, 10'd112, 10'd223);
    release_one = 1'b1;
    waitCycles(2);
    checkOutput("t4_outstanding", 64'(outstanding), 64'd2);
    checkOutput("t4_grant", 64'({eng_start, a_ack}), 64'b11);
    checkOutput("t4_oldest", 64'({a_rvalid, b_rvalid}), 64'b10);
    checkOutput("t4_oldest_data", 64'(a_rdata), 64'(engData(10'd111, 10'd222)));
    drainAll("t4_drain");

    $display("[TB] T5 spurious response");
    checkOutput("t5_err_clear", 64'(err), 64'd0);
    spurious_req = 1'b1;
    waitCycles(2);
    checkOutput("t5_err", 64'(err), 64'd1);
    checkOutput("t5_no_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    checkOutput("t5_outstanding", 64'(outstanding), 64'd0);
    rsp_a = 0;
    rsp_b = 0;
    applyStimulus(1'b0, 10'd1, 10'd2);
    applyStimulus(1'b1, 10'd513, 10'd3);
    drainAll("t5_drain");
    checkOutput("t5_rsp_a", 64'(rsp_a), 64'd1);
    checkOutput("t5_rsp_b", 64'(rsp_b), 64'd1);
    checkOutput("t5_err_sticky", 64'(err), 64'd1);

    $display("[TB] T6 reset mid-operation");
    eng_auto = 1'b0;
    applyStimulus(1'b0, 10'd300, 10'd1);
    applyStimulus(1'b0, 10'd301, 10'd2);
    applyStimulus(1'b1, 10'd900, 10'd3);
    waitCycles(8);
    checkOutput("t6_inflight", 64'(outstanding), 64'd3);
    rst_n = 1'b0;
    #1;
    checkOutput("t6_rst_ctrl", 64'({a_ack, b_ack, a_rvalid, b_rvalid, eng_start, err, outstanding}), 64'd0);
    checkOutput("t6_rst_eng_xy", 64'({eng_x, eng_y}), 64'd0);
    checkOutput("t6_rst_rdata", 64'({a_rdata, b_rdata} != 72'd0), 64'd0);
    waitCycles(2);
    rst_n = 1'b1;
    waitCycles(1);
    spurious_req = 1'b1;
    waitCycles(2);
    checkOutput("t6_err", 64'(err), 64'd1);
    checkOutput("t6_no_rvalid", 64'({a_rvalid, b_rvalid}), 64'd0);
    gnt_log.delete();
    applyStimulus(1'b1, 10'd901, 10'd4);
    applyStimulus(1'b0, 10'd302, 10'd5);
    n = 0;
    while (gnt_log.size() == 0 && n < 10) begin
      waitCycles(1);
      n++;
    end
    first_ok = (gnt_log.size() != 0) && (gnt_log[0] == 1'b0);
    checkOutput("t6_first_grant_a", 64'(first_ok), 64'd1);
    drainAll("t6_drain");

    checkOutput("end_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
